// File: rtl/mux1hot_pkg.sv
// Shared helpers for the streaming one-hot mux: index width and select decoding.
package mux1hot_pkg;

    // Widest select the helper functions accept; callers zero-extend into this.
    localparam int MAX_SEL = 64;

    // Width of the encoded channel index, never less than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Lowest-set-bit encoder; an all-zero select encodes to 0.
    function automatic int onehot_to_idx(input logic [MAX_SEL-1:0] sel);
        int idx;
        idx = 0;
        for (int k = MAX_SEL - 1; k >= 0; k--) begin
            if (sel[k]) begin
                idx = k;
            end
        end
        return idx;
    endfunction

    // True when exactly one bit of the select is set.
    function automatic logic is_onehot(input logic [MAX_SEL-1:0] sel);
        return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/mux1hot_skid.sv
// Generic 2-entry valid/ready register stage. The main register drives the output,
// the skid register catches the one beat that arrives while main is stalled, so
// in_ready is a plain flop with no combinational path from out_ready.
module mux1hot_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] main_data_reg, main_data_next;
    logic         main_valid_reg, main_valid_next;
    logic [W-1:0] skid_data_reg, skid_data_next;
    logic         skid_valid_reg, skid_valid_next;
    logic         in_ready_reg, in_ready_next;
    logic         push;
    logic         pop;

    assign push = in_valid & in_ready_reg;
    assign pop  = main_valid_reg & out_ready;

    // Next-state: refill main from skid first (preserves order), else from input.
    always_comb begin
        main_data_next  = main_data_reg;
        main_valid_next = main_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_valid_next = skid_valid_reg;
        if (!main_valid_reg || pop) begin
            if (skid_valid_reg) begin
                main_data_next  = skid_data_reg;
                main_valid_next = 1'b1;
                skid_valid_next = 1'b0;
            end else if (push) begin
                main_data_next  = in_data;
                main_valid_next = 1'b1;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (push) begin
            skid_data_next  = in_data;
            skid_valid_next = 1'b1;
        end
        in_ready_next = !skid_valid_next;
    end

    // State registers; in_ready comes up one clock after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_data_reg  <= '0;
            main_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b0;
        end else begin
            main_data_reg  <= main_data_next;
            main_valid_reg <= main_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_valid_reg <= skid_valid_next;
            in_ready_reg   <= in_ready_next;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_data  = main_data_reg;
    assign out_valid = main_valid_reg;

endmodule

// File: rtl/mux1hot_stream.sv
// Registered, flow-controlled one-hot mux with encoded index output.
// Optional select checking is enabled by defining MUX1HOT_SEL_CHECK_EN: beats whose
// select is not exactly one-hot are consumed but dropped, and counted.
module mux1hot_stream
    import mux1hot_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int INPUTS    = 3,
    parameter int ERR_CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [INPUTS*WIDTH-1:0]    in_data,
    input  logic [INPUTS-1:0]          in_sel,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [idx_w(INPUTS)-1:0]   out_idx,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       sel_err,
    output logic [ERR_CNT_W-1:0]       err_cnt
);

    localparam int IDX_W = idx_w(INPUTS);

    logic [WIDTH-1:0]   masked [INPUTS];
    logic [WIDTH-1:0]   mux_data;
    logic [IDX_W-1:0]   mux_idx;
    logic [MAX_SEL-1:0] sel_ext;
    logic               beat_ok;
    logic               push;

    assign sel_ext = {{(MAX_SEL-INPUTS){1'b0}}, in_sel};

    // AND stage of the AND-OR mux: each channel gated by its select bit.
    for (genvar gi = 0; gi < INPUTS; gi++) begin : g_mask
        assign masked[gi] = in_sel[gi] ? in_data[gi*WIDTH +: WIDTH] : '0;
    end

    // OR stage: multi-hot selects naturally merge the chosen channels.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < INPUTS; k++) begin
            mux_data = mux_data | masked[k];
        end
    end

    assign mux_idx = IDX_W'(onehot_to_idx(sel_ext));

`ifdef MUX1HOT_SEL_CHECK_EN
    logic                 accept;
    logic                 sel_err_reg;
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    assign beat_ok = is_onehot(sel_ext);
    assign accept  = in_valid & in_ready;

    // Flag accepted beats with a bad select and keep a saturating tally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_err_reg <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            sel_err_reg <= accept & !beat_ok;
            if (accept && !beat_ok && !(&err_cnt_reg)) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end
    end

    assign sel_err = sel_err_reg;
    assign err_cnt = err_cnt_reg;
`else
    assign beat_ok = 1'b1;
    assign sel_err = 1'b0;
    assign err_cnt = '0;
`endif

    // Bad beats still complete the input handshake; they just never enter the buffer.
    assign push = in_valid & beat_ok;

    mux1hot_skid #(
        .W(WIDTH + IDX_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_data  ({mux_idx, mux_data}),
        .in_valid (push),
        .in_ready (in_ready),
        .out_data ({out_idx, out_data}),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

endmodule
